// File: rtl/rll_pkg.sv
// Shared types and helpers for the keyed RLL pipeline.
// Holds the key FSM state encoding, key-index mapping and width-generic rotate.
package rll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ARMED
  } key_state_e;

  // Upper bound on DATA_W supported by the generic rotate helper.
  localparam int RLL_MAX_W = 256;

  function automatic int rll_key_idx(input int i, input int s, input int key_w);
    return (i + s) % key_w;
  endfunction

  function automatic logic [RLL_MAX_W-1:0] rll_rotl1(input logic [RLL_MAX_W-1:0] d,
                                                     input int w);
    logic [RLL_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < RLL_MAX_W; i++) begin
      if (i < w) r[(i + 1) % w] = d[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rll_key_stage.sv
// One key-gate + rotate-left-by-1 pipeline stage with valid/ready handshake.
// Key mask is applied when the word enters the stage, not carried with it.
module rll_key_stage
  import rll_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int KEY_W     = 32,
  parameter int STAGE_IDX = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [KEY_W-1:0]  mask_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] gated;
  logic              advance;

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_gate
    localparam int KI = rll_key_idx(gi, STAGE_IDX, KEY_W);
    assign gated[gi] = in_data_i[gi] ^ mask_i[KI];
  end

  assign advance     = out_ready_i || !valid_q;
  assign in_ready_o  = advance;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (advance) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = DATA_W'(rll_rotl1(RLL_MAX_W'(gated), DATA_W));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/rll_keyed_pipe.sv
// STAGES-deep keyed datapath with a serially loaded, atomically committed key.
// Input is blocked while a key is being shifted in; in-flight words drain on the old key.
module rll_keyed_pipe
  import rll_pkg::*;
#(
  parameter int               DATA_W  = 32,
  parameter int               KEY_W   = 32,
  parameter int               STAGES  = 2,
  parameter logic [KEY_W-1:0] KEY_POL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_load_start,
  input  logic              key_valid,
  input  logic              key_bit,
  output logic              key_armed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int CNT_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [KEY_W-1:0] active_q, active_d;
  logic [KEY_W-1:0] shifted;
  logic [KEY_W-1:0] mask;
  logic             load_busy;

  assign shifted = (shadow_q << 1) | KEY_W'(key_bit);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    // A restart wins over a bit presented in the same cycle; shadow is kept.
    if (key_load_start) begin
      state_d = LOAD;
      cnt_d   = '0;
    end else if (state_q == LOAD && key_valid) begin
      shadow_d = shifted;
      if (cnt_q == CNT_W'(KEY_W - 1)) begin
        active_d = shifted;
        state_d  = ARMED;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign key_armed = (state_q == ARMED);
  assign load_busy = (state_q == LOAD);
  assign mask      = active_q ^ KEY_POL;

  logic [STAGES:0]   vld;
  logic [STAGES:0]   rdy;
  logic [DATA_W-1:0] dat [0:STAGES];

  assign vld[0]      = in_valid && !load_busy;
  assign dat[0]      = in_data;
  assign rdy[STAGES] = out_ready;
  assign in_ready    = !load_busy && rdy[0];
  assign out_valid   = vld[STAGES];
  assign out_data    = dat[STAGES];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    rll_key_stage #(
      .DATA_W   (DATA_W),
      .KEY_W    (KEY_W),
      .STAGE_IDX(s)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (vld[s]),
      .in_ready_o (rdy[s]),
      .in_data_i  (dat[s]),
      .mask_i     (mask),
      .out_valid_o(vld[s+1]),
      .out_ready_i(rdy[s+1]),
      .out_data_o (dat[s+1])
    );
  end

endmodule

// File: tb/tb_rll_keyed_pipe.sv
// Directed + randomized bench for rll_keyed_pipe (8-bit data, 8-bit key, 2 stages, KEY_POL=A5).
module tb_rll_keyed_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_load_start = 1'b0;
  logic       key_valid = 1'b0;
  logic       key_bit = 1'b0;
  logic       key_armed;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;

  int         vectors = 0;
  int         errs = 0;
  logic [7:0] mkey = 8'h00;
  logic [7:0] q[$];
  logic [7:0] held;
  logic [7:0] rk;

  rll_keyed_pipe #(
    .DATA_W (8),
    .KEY_W  (8),
    .STAGES (2),
    .KEY_POL(8'hA5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_load_start(key_load_start),
    .key_valid     (key_valid),
    .key_bit       (key_bit),
    .key_armed     (key_armed),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data)
  );

  always #5 clk = ~clk;

  // Each stage XORs the word with the mask rotated right by the stage index,
  // then rotates the word left by one.
  function automatic logic [7:0] model(input logic [7:0] din, input logic [7:0] key);
    logic [7:0] m;
    logic [7:0] d;
    logic [7:0] mm;
    m = key ^ 8'hA5;
    d = din;
    for (int s = 0; s < 2; s++) begin
      mm = (m >> s) | (m << (8 - s));
      d  = d ^ mm;
      d  = {d[6:0], d[7]};
    end
    return d;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [7:0] e;
    #1;
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 8'(q.size() != 0), 8'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_out_data", out_data, e);
      end
    end
    if (in_valid && in_ready) q.push_back(model(in_data, mkey));
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [7:0] k);
    key_load_start = 1'b1;
    cycle();
    key_load_start = 1'b0;
    in_valid = 1'b0;
    chk("load_armed_low", 8'(key_armed), 8'd0);
    chk("load_in_ready", 8'(in_ready), 8'd0);
    for (int i = 0; i < 8; i++) begin
      key_valid = 1'b1;
      key_bit   = k[7-i];
      cycle();
      if (i == 6) chk("load_armed_early", 8'(key_armed), 8'd0);
    end
    key_valid = 1'b0;
    chk("load_armed", 8'(key_armed), 8'd1);
    mkey = k;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();
    chk("drain_empty", 8'(q.size()), 8'd0);
  endtask

  initial begin
    #2;
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_key_armed", 8'(key_armed), 8'd0);
    chk("rst_out_data", out_data, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 8'(in_ready), 8'd1);

    // No key loaded: active key is zero, word comes out corrupted.
    in_valid = 1'b1;
    in_data  = 8'h01;
    cycle();
    in_valid = 1'b0;
    chk("idle_lat1_valid", 8'(out_valid), 8'd0);
    cycle();
    chk("idle_valid", 8'(out_valid), 8'd1);
    chk("idle_data", out_data, 8'h37);
    cycle();

    load_key(8'hA5);
    in_valid = 1'b1;
    in_data  = 8'h01;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("key_valid", 8'(out_valid), 8'd1);
    chk("key_data", out_data, 8'h04);
    cycle();

    // Back-to-back stream.
    in_valid = 1'b1;
    in_data  = 8'h01;
    cycle();
    in_data = 8'h02;
    cycle();
    chk("stream0", out_data, 8'h04);
    in_data = 8'h80;
    cycle();
    chk("stream1", out_data, 8'h08);
    in_valid = 1'b0;
    cycle();
    chk("stream2", out_data, 8'h02);
    drain();

    // Output stall with full pipe.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'($urandom);
    cycle();
    in_data = 8'($urandom);
    cycle();
    in_data = 8'($urandom);
    held    = out_data;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_in_ready", 8'(in_ready), 8'd0);
      chk("stall_valid", 8'(out_valid), 8'd1);
      chk("stall_hold", out_data, held);
    end
    out_ready = 1'b1;
    cycle();
    drain();

    // Key restart while two words are in flight.
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    cycle();
    in_data = 8'($urandom);
    load_key(8'h00);
    drain();
    in_valid = 1'b1;
    in_data  = 8'h01;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("reload_data", out_data, 8'h37);
    drain();

    // Random traffic under an arbitrary key, stray key bits while armed.
    rk = 8'($urandom);
    load_key(rk);
    for (int i = 0; i < 150; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_data   = 8'($urandom);
      key_valid = 1'($urandom);
      key_bit   = 1'($urandom);
      cycle();
    end
    key_valid = 1'b0;
    drain();
    load_key(8'hA5);
    for (int i = 0; i < 100; i++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      cycle();
    end
    drain();

    // Reset in the middle of a key load.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'($urandom);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("pre_rst_valid", 8'(out_valid), 8'd1);
    key_load_start = 1'b1;
    cycle();
    key_load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1;
      key_bit   = 1'($urandom);
      cycle();
    end
    key_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_armed", 8'(key_armed), 8'd0);
    chk("midrst_valid", 8'(out_valid), 8'd0);
    chk("midrst_data", out_data, 8'h00);
    q.delete();
    mkey = 8'h00;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    load_key(8'hA5);
    in_valid = 1'b1;
    in_data  = 8'h01;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("post_rst_data", out_data, 8'h04);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
